apb_timer: RTL and testbench

//  8-bit APB-slave timer: programmable up/down counter TCNT clocked by a pclk prescaler (/2,/4,/8,/16).

---
 rtl/apb_timer.sv | 110 +++++++++++
 tb/tb_apb_timer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB slave timer: 8-bit up/down counter TCNT driven by a /2../16 pclk prescaler,
// with overflow/underflow flags in TSR mirrored onto interrupt lines.
module apb_timer #(
  localparam int ADDR_W = 8,
  localparam int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_ovf,
  output logic              tmr_udf
);

  localparam logic [DATA_W-1:0] TCR_MASK = 8'hB3;
  localparam logic [DATA_W-1:0] TSR_MASK = 8'h03;

  logic [DATA_W-1:0] r_tdr;
  logic [DATA_W-1:0] r_tcr;
  logic [DATA_W-1:0] r_tsr;
  logic [DATA_W-1:0] r_tcnt;
  logic [3:0]        r_pre;

  logic              w_valid;
  logic              w_access;
  logic              w_wr;
  logic              w_wr_tdr;
  logic              w_wr_tcr;
  logic              w_wr_tsr;
  logic              w_load;
  logic              w_dn;
  logic              w_run;
  logic              w_tick;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic [3:0]        w_div_m1;
  logic [DATA_W-1:0] w_tsr_sw;

  assign w_valid  = (paddr < 8'h04);
  assign w_access = psel & penable;
  assign w_wr     = w_access & pwrite & w_valid;
  assign w_wr_tdr = w_wr & (paddr[1:0] == 2'd0);
  assign w_wr_tcr = w_wr & (paddr[1:0] == 2'd1);
  assign w_wr_tsr = w_wr & (paddr[1:0] == 2'd2);

  assign w_load = r_tcr[7];
  assign w_dn   = r_tcr[5];
  assign w_run  = r_tcr[4] & ~w_load;

  always_comb begin
    w_div_m1 = 4'd1;
    case (r_tcr[1:0])
      2'd0: w_div_m1 = 4'd1;
      2'd1: w_div_m1 = 4'd3;
      2'd2: w_div_m1 = 4'd7;
      2'd3: w_div_m1 = 4'd15;
      default: w_div_m1 = 4'd1;
    endcase
  end

  assign w_tick    = w_run & (r_pre == w_div_m1);
  assign w_ovf_evt = w_tick & ~w_dn & (r_tcnt == 8'hFF);
  assign w_udf_evt = w_tick &  w_dn & (r_tcnt == 8'h00);

  // Software can only clear flags; a same-cycle hardware event is OR-ed in afterwards so it wins.
  assign w_tsr_sw = w_wr_tsr ? (r_tsr & pwdata & TSR_MASK) : r_tsr;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_tdr  <= '0;
      r_tcr  <= '0;
      r_tsr  <= '0;
      r_tcnt <= '0;
      r_pre  <= '0;
    end else begin
      if (w_wr_tdr) r_tdr <= pwdata;
      if (w_wr_tcr) r_tcr <= pwdata & TCR_MASK;
      r_tsr <= w_tsr_sw | {6'b0, w_udf_evt, w_ovf_evt};
      if (w_wr_tcr || !w_run || w_tick) r_pre <= '0;
      else                              r_pre <= r_pre + 4'd1;
      if (w_load)      r_tcnt <= r_tdr;
      else if (w_tick) r_tcnt <= w_dn ? r_tcnt - 8'd1 : r_tcnt + 8'd1;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && w_valid) begin
      case (paddr[1:0])
        2'd0: prdata = r_tdr;
        2'd1: prdata = r_tcr;
        2'd2: prdata = r_tsr;
        2'd3: prdata = r_tcnt;
        default: prdata = '0;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = w_access & ~w_valid;
  assign tmr_ovf = r_tsr[0];
  assign tmr_udf = r_tsr[1];

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed and randomized APB sequences checked against an
// analytic model that derives TCNT and flag state from tick counts since each TCR write.
`timescale 1ns/1ps
module tb_apb_timer;

  logic       pclk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;

  apb_timer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: a "segment" starts at each TCR write edge; counts are derived from elapsed edges.
  int tdr_m, tcr_m;
  int seg_w, seg_run, seg_load, seg_dn, seg_div, seg_v0;
  int st_ovf, st_udf, clr_ovf, clr_udf;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ticks_at(input int e);
    if (seg_run != 0 && e > seg_w) return (e - seg_w) / seg_div;
    return 0;
  endfunction

  function automatic int cnt_at(input int e);
    int k;
    k = ticks_at(e);
    if (seg_load != 0 && e > seg_w) return tdr_m;
    if (seg_run == 0) return seg_v0;
    if (seg_dn != 0) return ((seg_v0 - k) % 256 + 256) % 256;
    return (seg_v0 + k) % 256;
  endfunction

  // Edge of the most recent wrap (in direction dn_want) within the current segment, or -1.
  function automatic int wrap_edge(input int e, input int dn_want);
    int k, k1, kw;
    if (seg_run == 0 || seg_dn != dn_want) return -1;
    k  = ticks_at(e);
    k1 = (dn_want != 0) ? seg_v0 + 1 : 256 - seg_v0;
    if (k < k1) return -1;
    kw = k1 + ((k - k1) / 256) * 256;
    return seg_w + kw * seg_div;
  endfunction

  function automatic int tsr_at(input int e);
    int lo, lu, r;
    lo = imax(st_ovf, wrap_edge(e, 0));
    lu = imax(st_udf, wrap_edge(e, 1));
    r  = 0;
    if (lo >= 0 && lo >= clr_ovf) r = r | 1;
    if (lu >= 0 && lu >= clr_udf) r = r | 2;
    return r;
  endfunction

  function automatic int model_read(input int a, input int e);
    case (a)
      0: return tdr_m;
      1: return tcr_m;
      2: return tsr_at(e);
      3: return cnt_at(e);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    tdr_m = 0; tcr_m = 0;
    seg_w = cyc; seg_run = 0; seg_load = 0; seg_dn = 0; seg_div = 2; seg_v0 = 0;
    st_ovf = -1; st_udf = -1; clr_ovf = -1; clr_udf = -1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    int w, v;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    #1;
    check("pslverr_wr", {7'b0, pslverr}, (a > 8'h03) ? 8'h01 : 8'h00);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    w = cyc;
    v = int'(d);
    case (a)
      8'h00: tdr_m = v;
      8'h01: begin
        st_ovf   = imax(st_ovf, wrap_edge(w, 0));
        st_udf   = imax(st_udf, wrap_edge(w, 1));
        seg_v0   = cnt_at(w);
        tcr_m    = v & 8'hB3;
        seg_w    = w;
        seg_load = (v >> 7) & 1;
        seg_dn   = (v >> 5) & 1;
        seg_run  = (((v >> 4) & 1) != 0 && seg_load == 0) ? 1 : 0;
        seg_div  = 2 << (v & 3);
      end
      8'h02: begin
        if ((v & 1) == 0) clr_ovf = w;
        if ((v & 2) == 0) clr_udf = w;
      end
      default: ;
    endcase
  endtask

  task automatic apb_read_chk(input logic [7:0] a, input string tag);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    check(tag, prdata, 8'(model_read(int'(a), cyc)));
    if (a > 8'h03) check({tag, "_err"}, {7'b0, pslverr}, 8'h01);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic chk_all(input string pfx);
    int t;
    apb_read_chk(8'h00, {pfx, "_tdr"});
    apb_read_chk(8'h01, {pfx, "_tcr"});
    apb_read_chk(8'h02, {pfx, "_tsr"});
    apb_read_chk(8'h03, {pfx, "_tcnt"});
    t = tsr_at(cyc);
    check({pfx, "_ovf"}, {7'b0, tmr_ovf}, 8'(t & 1));
    check({pfx, "_udf"}, {7'b0, tmr_udf}, 8'((t >> 1) & 1));
  endtask

  task automatic read_const(input logic [7:0] a, input logic [7:0] exp, input string tag);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    check(tag, prdata, exp);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int t0, div, tdr_r, cks_r, dn_r;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_reset();
    run(3);
    preset = 1'b0;
    model_reset();
    step();

    // Reset state
    check("rst_pready", {7'b0, pready}, 8'h01);
    check("rst_pslverr", {7'b0, pslverr}, 8'h00);
    check("rst_prdata_idle", prdata, 8'h00);
    for (int a = 0; a < 4; a++) read_const(8'(a), 8'h00, "rst_reg");
    step();

    // Up count /8 from 0x35: overflow after 203 ticks
    apb_write(8'h00, 8'h35);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h12);
    t0 = cyc;
    run(400);
    read_const(8'h02, 8'h00, "up8_tsr_400");
    chk_all("up8_400");
    run(2048 - (cyc - t0));
    read_const(8'h02, 8'h01, "up8_tsr_2048");
    check("up8_ovf_2048", {7'b0, tmr_ovf}, 8'h01);
    chk_all("up8_2048");
    step();

    // Flag clear, then write-1 has no effect
    apb_write(8'h02, 8'h00);
    read_const(8'h02, 8'h00, "clr_tsr");
    check("clr_ovf", {7'b0, tmr_ovf}, 8'h00);
    apb_write(8'h02, 8'hFF);
    chk_all("w1_tsr");
    step();

    // TCR reserved bits, TCNT read-only
    apb_write(8'h01, 8'hCC);
    read_const(8'h01, 8'h80, "tcr_mask");
    apb_write(8'h03, 8'h55);
    chk_all("tcnt_ro");
    step();

    // Down count /2 from 0x79: underflow within 512 pclk
    apb_write(8'h00, 8'h79);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h30);
    run(512);
    read_const(8'h02, 8'h02, "dn2_tsr_512");
    check("dn2_udf", {7'b0, tmr_udf}, 8'h01);
    chk_all("dn2_512");
    step();

    // Prescaler sweep: overflow exactly div pclk after LOAD release from 0xFF
    for (int c = 0; c < 4; c++) begin
      div = 2 << c;
      apb_write(8'h01, 8'h80);
      apb_write(8'h02, 8'h00);
      apb_write(8'h00, 8'hFF);
      apb_write(8'h01, 8'(8'h10 | c));
      run(div - 1);
      check("cks_ovf_early", {7'b0, tmr_ovf}, 8'h00);
      step();
      check("cks_ovf_exact", {7'b0, tmr_ovf}, 8'h01);
      chk_all("cks");
      step();
    end

    // Out-of-range address
    apb_write(8'h10, 8'hAB);
    apb_read_chk(8'h10, "bad_rd");
    chk_all("bad_addr");
    step();

    // Randomized runs
    for (int n = 0; n < 8; n++) begin
      tdr_r = $urandom_range(0, 255);
      cks_r = $urandom_range(0, 3);
      dn_r  = $urandom_range(0, 1);
      apb_write(8'h00, 8'(tdr_r));
      apb_write(8'h01, 8'h80);
      if ($urandom_range(0, 1) == 1) apb_write(8'h02, 8'h00);
      apb_write(8'h01, 8'(8'h10 | (dn_r << 5) | cks_r));
      run($urandom_range(20, 1200));
      chk_all("rnd");
      step();
      apb_write(8'h02, 8'($urandom_range(0, 255)));
      run($urandom_range(0, 40));
      chk_all("rnd_clr");
      step();
    end

    // Asynchronous reset mid-count
    apb_write(8'h00, 8'h40);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h10);
    run(37);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h03;
    #2;
    preset = 1'b1;
    model_reset();
    #1;
    check("arst_tcnt", prdata, 8'h00);
    check("arst_ovf", {7'b0, tmr_ovf}, 8'h00);
    psel = 1'b0;
    step();
    preset = 1'b0;
    model_reset();
    chk_all("arst");
    run(40);
    chk_all("arst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
